// File: rtl/managed_banked_input_memory_pkg.sv
// Shared widths and the SPI slice write-enable mask for the banked input memory.
package input_memory_pkg;

  localparam int MAX_WORD_W      = 1024;
  localparam int DEF_WORD_W      = 64;
  localparam int DEF_ROWS        = 32;
  localparam int DEF_BANKS       = 2;
  localparam int DEF_SPI_ADDR_W  = 14;
  localparam int DEF_MSG_W       = 32;

  // Bit b is set when it belongs to message slice 'slice' of the word.
  function automatic logic [MAX_WORD_W-1:0] slice_mask(input int slice, input int msg_w);
    logic [MAX_WORD_W-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_WORD_W; b++) begin
      m[b] = ((b / msg_w) == slice);
    end
    return m;
  endfunction

endpackage

// File: rtl/managed_banked_input_memory_if.sv
// SPI decoder / compute datapath bus of the banked input memory.
interface managed_banked_input_memory_if #(
  parameter int INPUT_WORD_BIT_WIDTH    = 64,
  parameter int INPUT_ROWS              = 32,
  parameter int NUM_BANKS               = 2,
  parameter int START_ADDRESS_BIT_WIDTH = 14,
  parameter int MESSAGE_BIT_WIDTH       = 32
);
  localparam int ADDR_W = $clog2(INPUT_ROWS);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic                               write_new;
  logic                               read_sync;
  logic                               code_is_input;
  logic [START_ADDRESS_BIT_WIDTH-1:0] spi_address;
  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_in;
  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_out;
  logic                               spi_bank_commit;
  logic                               control_read_enable;
  logic                               control_write_enable;
  logic [ADDR_W-1:0]                  control_address_read;
  logic [ADDR_W-1:0]                  control_address_write;
  logic [INPUT_WORD_BIT_WIDTH-1:0]    control_data_in;
  logic [INPUT_WORD_BIT_WIDTH-1:0]    control_mask;
  logic                               control_bank_release;
  logic [INPUT_WORD_BIT_WIDTH-1:0]    input_data_out;
  logic                               bank_valid;
  logic                               banks_full;
  logic [BANK_W:0]                    bank_count;
  logic                               overflow_error;

  modport master (
    output write_new, read_sync, code_is_input, spi_address, spi_data_in, spi_bank_commit,
           control_read_enable, control_write_enable, control_address_read,
           control_address_write, control_data_in, control_mask, control_bank_release,
    input  spi_data_out, input_data_out, bank_valid, banks_full, bank_count, overflow_error
  );

  modport slave (
    input  write_new, read_sync, code_is_input, spi_address, spi_data_in, spi_bank_commit,
           control_read_enable, control_write_enable, control_address_read,
           control_address_write, control_data_in, control_mask, control_bank_release,
    output spi_data_out, input_data_out, bank_valid, banks_full, bank_count, overflow_error
  );
endinterface

// File: rtl/managed_banked_input_memory_scheduler.sv
// Ring pointers, committed-bank count, occupancy flags and sticky misuse flag.
// Release is evaluated before commit so a full ring can commit and release together.
module input_bank_scheduler #(
  parameter  int NUM_BANKS = 2,
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_wr_i,
  input  logic              ctrl_rd_i,
  input  logic              commit_i,
  input  logic              release_i,
  output logic [BANK_W-1:0] wr_ptr_o,
  output logic [BANK_W-1:0] rd_ptr_o,
  output logic [BANK_W:0]   count_o,
  output logic              valid_o,
  output logic              full_o,
  output logic              spi_wr_ok_o,
  output logic              error_o
);
  logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BANK_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              valid, full, commit_ok, release_ok;

  assign valid      = (count_q != '0);
  assign full       = (count_q == (BANK_W+1)'(NUM_BANKS));
  assign release_ok = release_i & valid;
  assign commit_ok  = commit_i & (~full | release_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (commit_ok)  wr_ptr_d = wr_ptr_q + BANK_W'(1);
    if (release_ok) rd_ptr_d = rd_ptr_q + BANK_W'(1);
    if (commit_ok && !release_ok)      count_d = count_q + (BANK_W+1)'(1);
    else if (release_ok && !commit_ok) count_d = count_q - (BANK_W+1)'(1);
    if ((spi_wr_i & full) | (ctrl_rd_i & ~valid) |
        (commit_i & ~commit_ok) | (release_i & ~release_ok)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;
  assign valid_o     = valid;
  assign full_o      = full;
  assign spi_wr_ok_o = spi_wr_i & ~full;
  assign error_o     = err_q;
endmodule

// File: rtl/managed_banked_input_memory.sv
// Ring of NUM_BANKS dual-port SRAM banks: SPI fills the head bank, compute reads/writes the tail.
// Port A serves SPI on the fill bank, port B the compute bank; both reads land one cycle later.
module managed_banked_input_memory
  import input_memory_pkg::*;
#(
  parameter int INPUT_WORD_BIT_WIDTH    = DEF_WORD_W,
  parameter int INPUT_ROWS              = DEF_ROWS,
  parameter int NUM_BANKS               = DEF_BANKS,
  parameter int START_ADDRESS_BIT_WIDTH = DEF_SPI_ADDR_W,
  parameter int MESSAGE_BIT_WIDTH       = DEF_MSG_W
) (
  input logic clk,
  input logic rst,
  managed_banked_input_memory_if.slave bus
);
  localparam int W        = INPUT_WORD_BIT_WIDTH;
  localparam int ADDR_W   = $clog2(INPUT_ROWS);
  localparam int SLICES   = INPUT_WORD_BIT_WIDTH / MESSAGE_BIT_WIDTH;
  localparam int SLICE_W  = $clog2(SLICES);
  localparam int SLICE_IW = (SLICE_W > 0) ? SLICE_W : 1;
  localparam int BANK_W   = $clog2(NUM_BANKS);

  logic                spi_wr, spi_rd, spi_wr_ok, ctrl_rd_ok, ctrl_wr_ok, bank_valid;
  logic [BANK_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]   spi_row;
  logic [SLICE_IW-1:0] spi_slice;
  logic [W-1:0]        spi_mask, spi_wdata;

  assign spi_wr     = bus.write_new & bus.code_is_input;
  assign spi_rd     = bus.read_sync & bus.code_is_input;
  assign ctrl_rd_ok = bus.control_read_enable & bank_valid;
  assign ctrl_wr_ok = bus.control_write_enable & bank_valid;
  assign spi_row    = bus.spi_address[SLICE_W +: ADDR_W];
  assign spi_wdata  = {SLICES{bus.spi_data_in}};
  assign spi_mask   = W'(slice_mask(int'(spi_slice), MESSAGE_BIT_WIDTH));

  if (SLICE_W > 0) begin : g_slice
    assign spi_slice = bus.spi_address[SLICE_IW-1:0];
  end else begin : g_no_slice
    assign spi_slice = '0;
  end

  if (START_ADDRESS_BIT_WIDTH > SLICE_W + ADDR_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.spi_address[START_ADDRESS_BIT_WIDTH-1:SLICE_W+ADDR_W];
  end

  input_bank_scheduler #(.NUM_BANKS(NUM_BANKS)) u_sched (
    .clk        (clk),
    .rst        (rst),
    .spi_wr_i   (spi_wr),
    .ctrl_rd_i  (bus.control_read_enable),
    .commit_i   (bus.spi_bank_commit),
    .release_i  (bus.control_bank_release),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .count_o    (bus.bank_count),
    .valid_o    (bank_valid),
    .full_o     (bus.banks_full),
    .spi_wr_ok_o(spi_wr_ok),
    .error_o    (bus.overflow_error)
  );
  assign bus.bank_valid = bank_valid;

  logic [W-1:0] a_rd [NUM_BANKS];
  logic [W-1:0] b_rd [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [W-1:0] mem [INPUT_ROWS];
    logic [W-1:0] a_rd_q, b_rd_q;
    logic         a_we, a_re, b_we, b_re;

    assign a_we = spi_wr_ok  & (wr_ptr == BANK_W'(b));
    assign a_re = spi_rd     & (wr_ptr == BANK_W'(b));
    assign b_we = ctrl_wr_ok & (rd_ptr == BANK_W'(b));
    assign b_re = ctrl_rd_ok & (rd_ptr == BANK_W'(b));

    // SPI writes are refused on a full ring, so the two write ports never hit the same bank.
    always_ff @(posedge clk) begin
      if (a_we) mem[spi_row] <= (mem[spi_row] & ~spi_mask) | (spi_wdata & spi_mask);
      if (b_we) mem[bus.control_address_write] <= (mem[bus.control_address_write] & ~bus.control_mask)
                                                | (bus.control_data_in & bus.control_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_rd_q <= '0;
        b_rd_q <= '0;
      end else begin
        if (a_re) a_rd_q <= mem[spi_row];
        if (b_re) b_rd_q <= mem[bus.control_address_read];
      end
    end

    assign a_rd[b] = a_rd_q;
    assign b_rd[b] = b_rd_q;
  end

  logic [BANK_W-1:0]   spi_bank_q, ctrl_bank_q;
  logic [SLICE_IW-1:0] spi_slice_q;
  logic [W-1:0]        spi_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_bank_q  <= '0;
      spi_slice_q <= '0;
      ctrl_bank_q <= '0;
    end else begin
      if (spi_rd) begin
        spi_bank_q  <= wr_ptr;
        spi_slice_q <= spi_slice;
      end
      if (ctrl_rd_ok) ctrl_bank_q <= rd_ptr;
    end
  end

  assign spi_word           = a_rd[spi_bank_q];
  assign bus.spi_data_out   = spi_word[spi_slice_q * MESSAGE_BIT_WIDTH +: MESSAGE_BIT_WIDTH];
  assign bus.input_data_out = b_rd[ctrl_bank_q];
endmodule
